// File: rtl/score_uart_pkg.sv
// Shared types and constants for the score UART reporter.
// Contents: FSM state enum, packet geometry, default header byte,
//           checksum and saturating-increment helpers.
package score_uart_pkg;

  // Reporter FSM states
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Packet geometry: header, P1, P2, checksum
  localparam int unsigned PKT_BYTES = 4;
  localparam int unsigned IDX_W     = $clog2(PKT_BYTES);
  localparam int unsigned BYTE_W    = 8;

  localparam logic [BYTE_W-1:0] DEFAULT_HEADER = 8'hA5;
  localparam logic [BYTE_W-1:0] OVERRUN_MAX    = 8'hFF;

  // Packet checksum: XOR of header and both score bytes
  function automatic logic [BYTE_W-1:0] pkt_chk(
    input logic [BYTE_W-1:0] hdr,
    input logic [BYTE_W-1:0] p1,
    input logic [BYTE_W-1:0] p2
  );
    return hdr ^ p1 ^ p2;
  endfunction

  // Increment that sticks at OVERRUN_MAX
  function automatic logic [BYTE_W-1:0] sat_inc(input logic [BYTE_W-1:0] v);
    return (v == OVERRUN_MAX) ? v : v + BYTE_W'(1);
  endfunction

endpackage

// File: rtl/score_uart_reporter_tx.sv
// 8N1 UART byte transmitter.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_start          1-cycle request to send i_data (ignored while o_active)
//   i_data[7:0]      byte to send, LSB first
//   o_tx             serial line, idle high
//   o_active         high from the start bit through the last stop-bit cycle
//   o_done           1-cycle pulse during the last cycle of the stop bit
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_active,
  output logic       o_done
);

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned BIT_W      = 4;
  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned SHIFT_W    = 9;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);

  logic [CNT_W-1:0]   baud_q;
  logic [BIT_W-1:0]   bit_q;
  // Bits still to be driven after the start bit: data LSB first, then stop
  logic [SHIFT_W-1:0] shift_q;

  // Bit/baud sequencing; o_tx is driven straight from a flop
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      o_tx     <= 1'b1;
      o_active <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (!o_active) begin
        if (i_start) begin
          o_active <= 1'b1;
          o_tx     <= 1'b0;
          shift_q  <= {1'b1, i_data};
          baud_q   <= '0;
          bit_q    <= '0;
        end
      end else if (baud_q == BAUD_LAST) begin
        baud_q  <= '0;
        o_tx    <= shift_q[0];
        // Refill with ones so the line returns to idle after the stop bit
        shift_q <= {1'b1, shift_q[SHIFT_W-1:1]};
        if (bit_q == BIT_LAST) begin
          o_active <= 1'b0;
          bit_q    <= '0;
        end else begin
          bit_q <= bit_q + BIT_W'(1);
        end
      end else begin
        baud_q <= baud_q + CNT_W'(1);
        // Registered so the pulse lands in the final stop-bit cycle
        if ((bit_q == BIT_LAST) && (baud_q == BAUD_PRE)) begin
          o_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/score_uart_reporter.sv
// Score reporter: snapshots both player scores on a goal pulse or host
// request and sends a 4-byte packet (HEADER, P1, P2, CHK) as 8N1 UART.
// Events arriving while a packet is in progress are merged into a single
// pending packet carrying the latest scores; merges beyond the first are
// counted in o_overrun.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_goal, i_req           1-cycle event pulses (OR-ed into one event)
//   i_score_P1/P2[7:0]      live scores
//   o_tx                    UART line, idle high
//   o_busy                  high while a packet is loaded or sent
//   o_overrun[7:0]          saturating count of extra merged events
module score_uart_reporter
  import score_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  HEADER       = DEFAULT_HEADER
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_goal,
  input  logic       i_req,
  input  logic [7:0] i_score_P1,
  input  logic [7:0] i_score_P2,
  output logic       o_tx,
  output logic       o_busy,
  output logic [7:0] o_overrun
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_BYTES - 1);

  state_t                          state_q;
  logic [BYTE_W-1:0]               snap_p1_q;
  logic [BYTE_W-1:0]               snap_p2_q;
  logic [PKT_BYTES-1:0][BYTE_W-1:0] fly_q;
  logic [IDX_W-1:0]                idx_q;
  logic                            pending_q;
  logic                            start_q;

  logic                            event_c;
  logic                            tx_active;
  logic                            tx_done;

  assign event_c = i_goal | i_req;

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_start  (start_q),
    .i_data   (fly_q[idx_q]),
    .o_tx     (o_tx),
    .o_active (tx_active),
    .o_done   (tx_done)
  );

  // Packet sequencer, snapshot/pending bookkeeping and overrun counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      snap_p1_q <= '0;
      snap_p2_q <= '0;
      fly_q     <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      start_q   <= 1'b0;
      o_busy    <= 1'b0;
      o_overrun <= '0;
    end else begin
      start_q <= 1'b0;
      o_busy  <= (state_q != S_IDLE);

      // Latest event always wins the snapshot
      if (event_c) begin
        snap_p1_q <= i_score_P1;
        snap_p2_q <= i_score_P2;
      end

      // Events during a packet become pending; further ones are overruns
      if (event_c && (state_q != S_IDLE)) begin
        if (pending_q) begin
          o_overrun <= sat_inc(o_overrun);
        end else begin
          pending_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (event_c) begin
            state_q <= S_LOAD;
          end
        end

        // Freeze the bytes to send so later snapshots cannot alter them
        S_LOAD: begin
          fly_q[0] <= HEADER;
          fly_q[1] <= snap_p1_q;
          fly_q[2] <= snap_p2_q;
          fly_q[3] <= pkt_chk(HEADER, snap_p1_q, snap_p2_q);
          idx_q    <= '0;
          state_q  <= S_SEND;
        end

        S_SEND: begin
          if (!tx_active) begin
            start_q <= 1'b1;
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (tx_done) begin
            if (idx_q == IDX_LAST) begin
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= S_SEND;
            end
          end
        end

        // An event landing here is sent next without needing the pending flag
        S_DONE: begin
          if (pending_q || event_c) begin
            pending_q <= 1'b0;
            state_q   <= S_LOAD;
          end else begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_uart_reporter.sv
// Self-checking bench for score_uart_reporter with CLKS_PER_BIT = 4.
// Expected packet bytes are queued when events are driven; a UART
// decoder stepped every falling clock edge pops and compares them.
module tb_score_uart_reporter;

  localparam int unsigned CPB       = 4;
  localparam int unsigned FRAME_CYC = 10 * CPB;
  localparam logic [7:0]  HDR       = 8'hA5;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_goal = 1'b0;
  logic       i_req = 1'b0;
  logic [7:0] i_score_P1 = 8'd0;
  logic [7:0] i_score_P2 = 8'd0;
  logic       o_tx;
  logic       o_busy;
  logic [7:0] o_overrun;

  int         n_tests = 0;
  int         n_fail  = 0;

  logic [7:0] sb [$];
  logic       mon_on = 1'b0;
  int         mon_cnt = 0;
  int         rx_count = 0;
  logic       mon_buf [FRAME_CYC];

  always #5 i_clk = ~i_clk;

  score_uart_reporter #(
    .CLKS_PER_BIT (CPB),
    .HEADER       (HDR)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_goal     (i_goal),
    .i_req      (i_req),
    .i_score_P1 (i_score_P1),
    .i_score_P2 (i_score_P2),
    .o_tx       (o_tx),
    .o_busy     (o_busy),
    .o_overrun  (o_overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_pkt(input logic [7:0] p1, input logic [7:0] p2);
    sb.push_back(HDR);
    sb.push_back(p1);
    sb.push_back(p2);
    sb.push_back(HDR ^ p1 ^ p2);
  endtask

  // Decode one captured frame and compare with the scoreboard head
  task automatic decode();
    logic [7:0] d;
    logic       stable;
    logic [7:0] exp;
    stable = 1'b1;
    for (int b = 0; b < 10; b++) begin
      for (int c = 1; c < int'(CPB); c++) begin
        if (mon_buf[b*CPB + c] !== mon_buf[b*CPB]) stable = 1'b0;
      end
    end
    for (int b = 0; b < 8; b++) d[b] = mon_buf[(b+1)*CPB];
    check("frame_start_stop_stable", {29'd0, mon_buf[0], mon_buf[9*CPB], stable}, 32'h3);
    check("rx_expected", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      exp = sb.pop_front();
      check($sformatf("rx_byte%0d", rx_count), {24'd0, d}, {24'd0, exp});
    end
    rx_count++;
  endtask

  task automatic mon_step();
    if (i_reset) begin
      mon_on  = 1'b0;
      mon_cnt = 0;
    end else begin
      if (!mon_on && (o_tx === 1'b0)) begin
        mon_on  = 1'b1;
        mon_cnt = 0;
      end
      if (mon_on) begin
        mon_buf[mon_cnt] = o_tx;
        mon_cnt++;
        if (mon_cnt == int'(FRAME_CYC)) begin
          decode();
          mon_on = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    mon_step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input logic g, input logic r);
    i_goal = g;
    i_req  = r;
    tick();
    i_goal = 1'b0;
    i_req  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n;
    n = 0;
    while ((o_busy || mon_on || (sb.size() != 0)) && (n < max)) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, 32'(n < max), 32'd1);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    ticks(2);
    i_reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    int bad;
    int n;
    logic found;

    // Reset values and a long idle stretch
    i_reset = 1'b1;
    ticks(3);
    check("rst_tx", {31'd0, o_tx}, 32'd1);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_overrun", {24'd0, o_overrun}, 32'd0);
    i_reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if ((o_tx !== 1'b1) || (o_busy !== 1'b0) || (o_overrun !== 8'd0)) bad++;
    end
    check("idle_bad_cycles", 32'(bad), 32'd0);

    // Single goal: latency to busy and to start bit, then the packet
    i_score_P1 = 8'd3;
    i_score_P2 = 8'd1;
    push_pkt(8'd3, 8'd1);
    pulse(1'b1, 1'b0);
    check("lat_busy_k", {31'd0, o_busy}, 32'd0);
    tick();
    check("lat_busy_k1", {31'd0, o_busy}, 32'd1);
    tick();
    check("lat_tx_k2", {31'd0, o_tx}, 32'd1);
    tick();
    check("lat_tx_k3", {31'd0, o_tx}, 32'd0);
    wait_idle("goal", 400);
    check("goal_overrun", {24'd0, o_overrun}, 32'd0);

    // Simultaneous goal and request is one event
    i_score_P1 = 8'd0;
    i_score_P2 = 8'd0;
    push_pkt(8'd0, 8'd0);
    pulse(1'b1, 1'b1);
    wait_idle("both", 600);
    check("both_overrun", {24'd0, o_overrun}, 32'd0);

    // Two events during packet 1 merge into one follow-up packet
    i_score_P1 = 8'd1;
    i_score_P2 = 8'd0;
    push_pkt(8'd1, 8'd0);
    pulse(1'b1, 1'b0);
    ticks(20);
    i_score_P1 = 8'd2;
    pulse(1'b1, 1'b0);
    ticks(20);
    i_score_P1 = 8'd3;
    pulse(1'b1, 1'b0);
    push_pkt(8'd3, 8'd0);
    bad = 0;
    n = 0;
    // Busy must not drop between the two packets
    while ((sb.size() > 0) && (n < 1000)) begin
      tick();
      n++;
      if (!o_busy && (sb.size() > 0) && (n > 2)) bad++;
    end
    check("merge_back_to_back", 32'(bad), 32'd0);
    wait_idle("merge", 1000);
    check("merge_overrun", {24'd0, o_overrun}, 32'd1);

    // Reset in the middle of the second byte abandons the packet
    i_score_P1 = 8'd4;
    i_score_P2 = 8'd4;
    push_pkt(8'd4, 8'd4);
    n = rx_count;
    pulse(1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if ((rx_count == n + 1) && mon_on && (mon_cnt >= int'(3 * CPB))) found = 1'b1;
    end
    check("mid_byte2_reached", {31'd0, found}, 32'd1);
    i_reset = 1'b1;
    tick();
    check("midrst_tx", {31'd0, o_tx}, 32'd1);
    check("midrst_busy", {31'd0, o_busy}, 32'd0);
    check("midrst_overrun", {24'd0, o_overrun}, 32'd0);
    i_reset = 1'b0;
    sb.delete();
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if ((o_tx !== 1'b1) || (o_busy !== 1'b0)) bad++;
    end
    check("postrst_quiet", 32'(bad), 32'd0);
    i_score_P1 = 8'd5;
    i_score_P2 = 8'd7;
    push_pkt(8'd5, 8'd7);
    pulse(1'b1, 1'b0);
    wait_idle("postrst", 400);

    // Continuous events: overrun saturates, three identical packets
    do_reset();
    i_score_P1 = 8'd9;
    i_score_P2 = 8'd9;
    push_pkt(8'd9, 8'd9);
    push_pkt(8'd9, 8'd9);
    push_pkt(8'd9, 8'd9);
    i_goal = 1'b1;
    ticks(301);
    i_goal = 1'b0;
    wait_idle("sat", 2000);
    check("sat_overrun", {24'd0, o_overrun}, 32'd255);
    ticks(5);
    check("sat_idle_busy", {31'd0, o_busy}, 32'd0);

    check("sb_final_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
